// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N_CH-input valid/ready multiplexer with a registered output stage.
// The source channel is either picked directly by sel (mode=0) or by a
// round-robin arbiter whose search starts at rr_ptr (mode=1). The output
// register accepts a new word whenever it is empty or being drained that cycle,
// so a continuously ready consumer sees one word per clock.
module rr_mux_arb #(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 16,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] g;
    logic             grant_exists;
    logic             gv;
    logic             free;
    logic             ld;
    int               p;

    // Split the flattened input bus into one word per channel.
    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    // The output register can take a word when empty or emptying this cycle.
    assign free = !out_valid || out_ready;
    assign ld   = gv && free;

    // Grant selection: direct index in static mode, rotating priority otherwise.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        g            = '0;
        grant_exists = 1'b0;
        gv           = 1'b0;
        p            = 0;
        if (!mode) begin
            // Out-of-range sel gives no grant and never indexes past in_valid.
            if (int'(sel) < N_CH) begin
                grant_exists = 1'b1;
                g            = sel;
                gv           = in_valid[sel];
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid
            // channel after rr_ptr (with explicit wrap) is the last one kept.
            for (int i = N_CH - 1; i >= 0; i--) begin
                p = int'(rr_ptr) + i;
                if (p >= N_CH) begin
                    p = p - N_CH;
                end
                if (in_valid[p[SEL_W-1:0]]) begin
                    g            = p[SEL_W-1:0];
                    grant_exists = 1'b1;
                end
            end
            gv = grant_exists;
        end
    end

    // One-hot ready toward the granted channel only when the register is free.
    always_comb begin
        in_ready = '0;
        if (free && grant_exists) begin
            in_ready[g] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates
            // from the values present before the edge.
            if (ld) begin
                out_data  <= ch_data[g];
                out_ch    <= g;
                out_valid <= 1'b1;
                if (mode) begin
                    rr_ptr <= (int'(g) == N_CH - 1) ? '0 : g + SEL_W'(1);
                end
            end else if (out_ready) begin
                // Drained with nothing to replace it: data and channel hold.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
